// File: rtl/accum_sequencer.sv
// accum_sequencer: command-side driver for one accumulator slice.
// Tags each accepted slice result beat with an accumulator address and op
// (SET/ADD/ADD_OUT/SET_OUT) over a tile of num_rows addresses x num_chunks
// reduction passes. Short passes get a stall so that an address is never
// re-issued before its read-modify-write in the accumulator has retired.
// Optional feature macro: ACCUM_SEQ_ERR_EN adds a sticky protocol-error flag o_err.
//
// state  | meaning
// IDLE   | waiting for i_start, config registers free to reload
// RUN    | o_ready high, each accepted beat becomes one accumulator command
// GAP    | pass boundary stall for short passes, o_ready low
// DONE   | one-cycle o_done pulse, then back to IDLE

module accum_sequencer #(
   parameter int SLICE_ODATAW = 26,
   parameter int ACCUM_DEPTH  = 512,
   parameter int ACCUM_ADDRW  = $clog2(ACCUM_DEPTH),
   parameter int CHUNKW       = 8,
   parameter int HAZARD_GAP   = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_start,
   input  logic [ACCUM_ADDRW-1:0]  i_base_addr,
   input  logic [ACCUM_ADDRW-1:0]  i_num_rows,
   input  logic [CHUNKW-1:0]       i_num_chunks,
   input  logic                    i_slice_valid,
   input  logic [SLICE_ODATAW-1:0] i_slice_data,
   output logic                    o_ready,
   output logic [ACCUM_ADDRW-1:0]  o_accum_addr,
   output logic [1:0]              o_accum_op,
   output logic                    o_valid,
   output logic [SLICE_ODATAW-1:0] o_accum_data,
   output logic                    o_busy,
   output logic                    o_done
`ifdef ACCUM_SEQ_ERR_EN
   ,
   output logic                    o_err
`endif
);

   localparam logic [1:0] OP_SET     = 2'd0;
   localparam logic [1:0] OP_ADD     = 2'd1;
   localparam logic [1:0] OP_ADD_OUT = 2'd2;
   localparam logic [1:0] OP_SET_OUT = 2'd3;

   localparam logic [ACCUM_ADDRW-1:0] HAZ_GAP_A = ACCUM_ADDRW'(HAZARD_GAP);
   localparam logic [ACCUM_ADDRW-1:0] ONE_A     = ACCUM_ADDRW'(1);
   localparam logic [CHUNKW-1:0]      ONE_C     = CHUNKW'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_GAP  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [ACCUM_ADDRW-1:0]  base_q, base_d;
   logic [ACCUM_ADDRW-1:0]  rows_q, rows_d;
   logic [CHUNKW-1:0]       chunks_q, chunks_d;
   logic [ACCUM_ADDRW-1:0]  row_cnt_q, row_cnt_d;
   logic [CHUNKW-1:0]       chunk_cnt_q, chunk_cnt_d;
   logic [ACCUM_ADDRW-1:0]  gap_cnt_q, gap_cnt_d;
   logic                    valid_q, valid_d;
   logic [ACCUM_ADDRW-1:0]  addr_q, addr_d;
   logic [1:0]              op_q, op_d;
   logic [SLICE_ODATAW-1:0] data_q, data_d;

   logic                    row_last;
   logic                    chunk_last;
   logic [1:0]              op_sel;
   logic [ACCUM_ADDRW-1:0]  gap_load;

   // Per-pass decode: end-of-pass/end-of-tile flags, op for the current pass,
   // and the gap length (down-counter terminal value 0 means last gap cycle).
   always_comb begin
      row_last   = (row_cnt_q == rows_q - ONE_A);
      chunk_last = (chunk_cnt_q == chunks_q - ONE_C);
      gap_load   = HAZ_GAP_A - rows_q - ONE_A;
      if (chunks_q == ONE_C) begin
         op_sel = OP_SET_OUT;
      end else if (chunk_cnt_q == '0) begin
         op_sel = OP_SET;
      end else if (chunk_last) begin
         op_sel = OP_ADD_OUT;
      end else begin
         op_sel = OP_ADD;
      end
   end

   // Next-state and datapath control for the tile sequencer.
   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      rows_d      = rows_q;
      chunks_d    = chunks_q;
      row_cnt_d   = row_cnt_q;
      chunk_cnt_d = chunk_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      valid_d     = 1'b0;
      addr_d      = addr_q;
      op_d        = op_q;
      data_d      = data_q;
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               base_d      = i_base_addr;
               rows_d      = i_num_rows;
               chunks_d    = i_num_chunks;
               row_cnt_d   = '0;
               chunk_cnt_d = '0;
               if (i_num_rows == '0 || i_num_chunks == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (i_slice_valid) begin
               valid_d = 1'b1;
               data_d  = i_slice_data;
               addr_d  = base_q + row_cnt_q;
               op_d    = op_sel;
               if (row_last) begin
                  row_cnt_d   = '0;
                  chunk_cnt_d = chunk_cnt_q + ONE_C;
                  if (chunk_last) begin
                     state_d = S_DONE;
                  end else if (rows_q < HAZ_GAP_A) begin
                     state_d   = S_GAP;
                     gap_cnt_d = gap_load;
                  end
               end else begin
                  row_cnt_d = row_cnt_q + ONE_A;
               end
            end
         end
         S_GAP: begin
            if (gap_cnt_q == '0) begin
               state_d = S_RUN;
            end else begin
               gap_cnt_d = gap_cnt_q - ONE_A;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, counters, latched config and registered accumulator command.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         base_q      <= '0;
         rows_q      <= '0;
         chunks_q    <= '0;
         row_cnt_q   <= '0;
         chunk_cnt_q <= '0;
         gap_cnt_q   <= '0;
         valid_q     <= 1'b0;
         addr_q      <= '0;
         op_q        <= '0;
         data_q      <= '0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         rows_q      <= rows_d;
         chunks_q    <= chunks_d;
         row_cnt_q   <= row_cnt_d;
         chunk_cnt_q <= chunk_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         valid_q     <= valid_d;
         addr_q      <= addr_d;
         op_q        <= op_d;
         data_q      <= data_d;
      end
   end

   // Handshake and status are decoded from registered state only.
   always_comb begin
      o_ready      = (state_q == S_RUN);
      o_busy       = (state_q == S_RUN) || (state_q == S_GAP);
      o_done       = (state_q == S_DONE);
      o_valid      = valid_q;
      o_accum_addr = addr_q;
      o_accum_op   = op_q;
      o_accum_data = data_q;
   end

`ifdef ACCUM_SEQ_ERR_EN
   logic err_q, err_d;

   // Sticky flag for upstream protocol misuse; never alters tile behaviour.
   always_comb begin
      err_d = err_q;
      if (i_start && state_q != S_IDLE) begin
         err_d = 1'b1;
      end
      if (i_slice_valid && (state_q == S_IDLE || state_q == S_DONE)) begin
         err_d = 1'b1;
      end
   end

   // Error flag register, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign o_err = err_q;
`endif

endmodule
